fir_y_out_fifo: RTL
===================

Name: fir_y_out_fifo

Overview:
- AXI-Stream buffer directly downstream of the FIR output port (sm_*); absorbs y[t] samples and replays them to the host/testbench consumer under backpressure.
- The FIR asserts sm_tvalid without honouring sm_tready, so this block also detects and counts dropped samples, and keeps occupancy, high-watermark and completed-frame status for debug/AXI-Lite readback.

Parameters:
- pDATA_WIDTH, 32, width of y[t] data
- pPTR_WIDTH, 4, pointer width; DEPTH = 2**pPTR_WIDTH entries (default 16)
- pCNT_WIDTH, 10, width of drop and frame counters (matches 600-sample data length range)

Ports:
- axis_clk  in  1  single clock for the block
- axis_rst  in  1  asynchronous reset, active-high; all state cleared immediately on assertion
- clear  in  1  synchronous flush, active-high, one-cycle pulse
- s_tvalid  in  1  input sample valid (from FIR sm_tvalid)
- s_tready  out  1  input ready (to FIR sm_tready)
- s_tdata  in  pDATA_WIDTH  input y[t]
- s_tlast  in  1  input last-sample marker
- m_tvalid  out  1  output sample valid
- m_tready  in  1  downstream ready
- m_tdata  out  pDATA_WIDTH  output y[t]
- m_tlast  out  1  output last marker
- fifo_count  out  pPTR_WIDTH+1  current occupancy, 0..DEPTH
- high_water  out  pPTR_WIDTH+1  max occupancy since reset/clear
- overflow  out  1  sticky: at least one sample dropped
- drop_cnt  out  pCNT_WIDTH  dropped-sample count, saturating
- frame_cnt  out  pCNT_WIDTH  frames fully emitted (tlast popped), wrapping

Behaviour:
- Reset (axis_rst=1, async): rd_ptr=wr_ptr=0, fifo_count=0, high_water=0, overflow=0, drop_cnt=0, frame_cnt=0; outputs m_tvalid=0, m_tlast=0, m_tdata=0 (read of cleared entry 0); s_tready=1. Storage array also reset to 0. Reset mid-stream discards all contents; no partial frame survives.
- Storage: DEPTH entries of {tlast, data}; pointers are pPTR_WIDTH+1 bits, full when MSBs differ and lower bits equal, empty when equal.
- push = s_tvalid & s_tready; pop = m_tvalid & m_tready; both evaluated at the same rising edge.
- s_tready = !full (combinational from registered pointers). When full, push is refused even if a pop occurs in the same cycle; s_tready rises the cycle after the pop.
- m_tvalid = !empty; m_tdata/m_tlast = entry at rd_ptr (first-word fall-through). Latency: sample pushed at edge N is on m_* from edge N (visible during cycle N+1) when FIFO was empty.
- m_tdata/m_tlast held stable while m_tvalid=1 and m_tready=0.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- high_water updated to next fifo_count whenever that value exceeds it.
- Drop: s_tvalid=1 & s_tready=0 at an edge -> sample discarded, overflow<=1, drop_cnt+=1 saturating at all-ones. A dropped sample with s_tlast=1 loses its tlast (not re-inserted).
- frame_cnt += 1 on pop with m_tlast=1; wraps at 2**pCNT_WIDTH.
- clear=1 at an edge: pointers, fifo_count, high_water, overflow, drop_cnt, frame_cnt -> 0; any simultaneous push/pop/drop ignored. Storage contents not required to be zeroed. axis_rst has priority over clear.
- No combinational path from s_tvalid to s_tready or from m_tready to m_tvalid.

Test Plan:
- Reset values: assert axis_rst for 3 cycles mid-run with 5 entries held -> immediately m_tvalid=0, fifo_count=0, s_tready=1, all status 0; release -> idle.
- Pass-through: m_tready=1, push 600 samples y=k (k=0..599) with s_tlast on k=599 -> outputs match in order, one-cycle latency, m_tlast only on 599, frame_cnt=1, high_water=1, drop_cnt=0.
- Fill and drain: m_tready=0, push 16 samples 0x100..0x10F -> fifo_count=16, s_tready=0; then m_tready=1 -> 16 pops in order, fifo_count reaches 0, high_water stays 16.
- Overflow: FIFO full, m_tready=0, drive s_tvalid 3 more cycles (values 0xAA..0xAC) -> overflow=1, drop_cnt=3, contents unchanged, none of 0xAA..0xAC ever emitted.
- Simultaneous push/pop: fifo_count=8, s_tvalid=m_tready=1 for 20 cycles -> fifo_count stays 8, order preserved; at full with pop+push same edge -> push refused, drop_cnt+1, count 15.
- Clear: fifo_count=5, overflow=1, frame_cnt=2, pulse clear with s_tvalid=1 -> next cycle all status 0, m_tvalid=0, the concurrent sample not stored.

Source files
------------

// File: rtl/fir_y_out_fifo.sv
// fir_y_out_fifo: FWFT AXI-Stream buffer for FIR y[t] output with drop, occupancy and frame status.
module fir_y_out_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pPTR_WIDTH  = 4,
    parameter int pCNT_WIDTH  = 10
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   clear,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    output logic [pPTR_WIDTH:0]    fifo_count,
    output logic [pPTR_WIDTH:0]    high_water,
    output logic                   overflow,
    output logic [pCNT_WIDTH-1:0]  drop_cnt,
    output logic [pCNT_WIDTH-1:0]  frame_cnt
);
    localparam int DEPTH = 2 ** pPTR_WIDTH;
    logic [pDATA_WIDTH:0]  r_mem [DEPTH];
    logic [pPTR_WIDTH:0]   r_wr, r_rd, r_cnt, r_hw, w_cnt_nxt;
    logic [pCNT_WIDTH-1:0] r_drop, r_frame;
    logic                  r_ovf, w_full, w_empty, w_push, w_pop, w_drop;
    assign w_full    = (r_wr[pPTR_WIDTH] != r_rd[pPTR_WIDTH]) && (r_wr[pPTR_WIDTH-1:0] == r_rd[pPTR_WIDTH-1:0]);
    assign w_empty   = r_wr == r_rd;
    assign w_push    = s_tvalid && !w_full;
    assign w_pop     = !w_empty && m_tready;
    assign w_drop    = s_tvalid && w_full;
    assign w_cnt_nxt = r_cnt + (pPTR_WIDTH+1)'(w_push) - (pPTR_WIDTH+1)'(w_pop);
    assign s_tready  = !w_full;
    assign m_tvalid  = !w_empty;
    assign {m_tlast, m_tdata} = r_mem[r_rd[pPTR_WIDTH-1:0]];
    assign fifo_count = r_cnt;
    assign high_water = r_hw;
    assign overflow   = r_ovf;
    assign drop_cnt   = r_drop;
    assign frame_cnt  = r_frame;
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !clear) begin
            r_mem[r_wr[pPTR_WIDTH-1:0]] <= {s_tlast, s_tdata};
        end
    end
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst || clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_hw    <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
            r_frame <= '0;
        end else begin
            r_wr  <= r_wr + (pPTR_WIDTH+1)'(w_push);
            r_rd  <= r_rd + (pPTR_WIDTH+1)'(w_pop);
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt > r_hw) r_hw <= w_cnt_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (!(&r_drop)) r_drop <= r_drop + 1'b1;
            end
            // a dropped tlast is simply lost; only emitted frames are counted
            if (w_pop && m_tlast) r_frame <= r_frame + 1'b1;
        end
    end
endmodule
